// File: rtl/pong_game_engine.sv
// Two-player pong: paddles, round ball, scores and a serve/play/miss/over FSM.
// Everything except rendering and the miss pulse advances once per frame (refr_tick).
module pong_paddle #(
  parameter int MAX_Y      = 480,
  parameter int BAR_X      = 32,
  parameter int BAR_W      = 4,
  parameter int BAR_Y_SIZE = 72,
  parameter int BAR_V      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       recenter,
  input  logic [1:0] btn,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic [9:0] y,
  output logic       on
);
  localparam logic [9:0] Y_INIT = 10'((MAX_Y - BAR_Y_SIZE) / 2);
  localparam logic [9:0] SZ     = 10'(BAR_Y_SIZE);
  localparam logic [9:0] V      = 10'(BAR_V);

  always_ff @(posedge clk) begin
    if (!reset || recenter) y <= Y_INIT;
    else if (en) begin
      if (btn == 2'b10 && (y + SZ - 10'd1) < 10'(MAX_Y - 1 - BAR_V)) y <= y + V;
      else if (btn == 2'b01 && y > V) y <= y - V;
    end
  end

  assign on = (pix_x >= 10'(BAR_X)) && (pix_x <= 10'(BAR_X + BAR_W - 1)) &&
              (pix_y >= y) && (pix_y <= y + SZ - 10'd1);
endmodule

module pong_game_engine #(
  parameter int MAX_X       = 640,
  parameter int MAX_Y       = 480,
  parameter int BAR_L_X     = 32,
  parameter int BAR_R_X     = 600,
  parameter int BAR_W       = 4,
  parameter int BAR_Y_SIZE  = 72,
  parameter int BAR_V       = 4,
  parameter int BALL_V      = 2,
  parameter int WIN_SCORE   = 9,
  parameter int MISS_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       video_on,
  input  logic [1:0] btn_l,
  input  logic [1:0] btn_r,
  input  logic       serve,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic [2:0] graph_rgb,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       miss_tick
);
  localparam int         CW     = $clog2(MISS_FRAMES + 1);
  localparam logic [9:0] BX0    = 10'(MAX_X / 2 - 4);
  localparam logic [9:0] BY0    = 10'(MAX_Y / 2 - 4);
  localparam logic [9:0] PV     = 10'(BALL_V);
  localparam logic [9:0] NV     = 10'(-BALL_V);
  localparam logic [9:0] SZ     = 10'(BAR_Y_SIZE);

  typedef enum logic [1:0] {IDLE, PLAY, MISS, OVER} state_t;
  state_t state, state_nxt;

  logic [9:0] ball_x, ball_y, x_delta, y_delta, ball_r, ball_b, x_nxt, y_nxt;
  logic [CW-1:0] miss_cnt;
  logic conc_l;
  logic refr_tick, hit_l_edge, hit_r_edge, bnc_top, bnc_bot, pad_l, pad_r;
  logic score_l_ev, score_r_ev, miss_last, restart;
  logic [1:0][9:0] bar_y;
  logic [1:0][1:0] btn;
  logic [1:0]      pad_on;

  assign refr_tick = (pix_y == 10'(MAX_Y + 1)) && (pix_x == '0);
  assign btn       = {btn_r, btn_l};
  assign restart   = refr_tick && serve && (state == OVER);

  // index 0 = left paddle, 1 = right paddle
  for (genvar i = 0; i < 2; i++) begin : g_pad
    pong_paddle #(
      .MAX_Y(MAX_Y), .BAR_X((i == 0) ? BAR_L_X : BAR_R_X), .BAR_W(BAR_W),
      .BAR_Y_SIZE(BAR_Y_SIZE), .BAR_V(BAR_V)
    ) u_pad (
      .clk(clk), .reset(reset), .en(refr_tick && (state != OVER)),
      .recenter(restart), .btn(btn[i]), .pix_x(pix_x), .pix_y(pix_y),
      .y(bar_y[i]), .on(pad_on[i])
    );
  end

  assign ball_r     = ball_x + 10'd7;
  assign ball_b     = ball_y + 10'd7;
  assign hit_l_edge = ball_x < PV;
  assign hit_r_edge = ball_r > 10'(MAX_X - 1 - BALL_V);
  // bounces only reverse a delta that points into the obstacle, so the ball cannot stick
  assign bnc_top    = (ball_y <= PV) && y_delta[9];
  assign bnc_bot    = (ball_b >= 10'(MAX_Y - 1 - BALL_V)) && !y_delta[9] && (y_delta != '0);
  assign pad_l      = (ball_x >= 10'(BAR_L_X)) && (ball_x <= 10'(BAR_L_X + BAR_W - 1)) &&
                      (ball_b >= bar_y[0]) && (ball_y <= bar_y[0] + SZ - 10'd1) && x_delta[9];
  assign pad_r      = (ball_r >= 10'(BAR_R_X)) && (ball_r <= 10'(BAR_R_X + BAR_W - 1)) &&
                      (ball_b >= bar_y[1]) && (ball_y <= bar_y[1] + SZ - 10'd1) &&
                      !x_delta[9] && (x_delta != '0);
  assign x_nxt      = pad_l ? PV : (pad_r ? NV : x_delta);
  assign y_nxt      = bnc_top ? PV : (bnc_bot ? NV : y_delta);
  assign score_r_ev = refr_tick && (state == PLAY) && hit_l_edge;
  assign score_l_ev = refr_tick && (state == PLAY) && !hit_l_edge && hit_r_edge;
  assign miss_last  = miss_cnt == CW'(MISS_FRAMES - 1);
  assign game_over  = state == OVER;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (refr_tick && serve) state_nxt = PLAY;
      PLAY: if (score_l_ev || score_r_ev) state_nxt = MISS;
      MISS: if (refr_tick && miss_last)
              state_nxt = (score_l >= 4'(WIN_SCORE) || score_r >= 4'(WIN_SCORE)) ? OVER : IDLE;
      OVER: if (refr_tick && serve) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ball_x <= BX0; ball_y <= BY0; x_delta <= PV; y_delta <= PV;
      score_l <= '0; score_r <= '0; miss_cnt <= '0; conc_l <= 1'b0; miss_tick <= 1'b0;
    end else begin
      miss_tick <= score_l_ev || score_r_ev;
      if (score_l_ev) begin
        score_l <= (score_l == 4'hF) ? score_l : score_l + 4'd1;
        conc_l  <= 1'b0;
      end
      if (score_r_ev) begin
        score_r <= (score_r == 4'hF) ? score_r : score_r + 4'd1;
        conc_l  <= 1'b1;
      end
      if (refr_tick && state == PLAY && !hit_l_edge && !hit_r_edge) begin
        x_delta <= x_nxt;          y_delta <= y_nxt;
        ball_x  <= ball_x + x_nxt; ball_y  <= ball_y + y_nxt;
      end
      if (refr_tick && state == MISS) begin
        if (miss_last) begin
          miss_cnt <= '0; ball_x <= BX0; ball_y <= BY0;
          x_delta  <= conc_l ? NV : PV; y_delta <= PV;
        end else miss_cnt <= miss_cnt + CW'(1);
      end
      if (restart) begin
        score_l <= '0; score_r <= '0;
      end
    end
  end

  logic [2:0] dx, dy;
  logic [7:0] rom_row;
  logic       ball_on;
  assign dx = 3'(pix_x - ball_x);
  assign dy = 3'(pix_y - ball_y);

  always_comb begin
    rom_row = 8'h3C;
    case (dy)
      3'd0, 3'd7: rom_row = 8'h3C;
      3'd1, 3'd6: rom_row = 8'h7E;
      default:    rom_row = 8'hFF;
    endcase
  end

  assign ball_on = (pix_x >= ball_x) && (pix_x <= ball_r) && (pix_y >= ball_y) &&
                   (pix_y <= ball_b) && rom_row[dx] && (state == IDLE || state == PLAY);

  always_ff @(posedge clk) begin
    if (!reset)          graph_rgb <= 3'b000;
    else if (!video_on)  graph_rgb <= 3'b000;
    else if (pad_on[0])  graph_rgb <= 3'b001;
    else if (pad_on[1])  graph_rgb <= 3'b010;
    else if (ball_on)    graph_rgb <= 3'b100;
    else                 graph_rgb <= (state == OVER) ? 3'b111 : 3'b110;
  end
endmodule
